// File: rtl/periph_bus_master.sv
// ============================================================================
//  Module   : periph_bus_master
//  Purpose  : Initiator for the peripherals register bus (A/WD/WE/RD).
//             Queues read / write / atomic bit-set / atomic bit-clear
//             requests in a small FIFO and turns each one into registered
//             bus cycles. Read data (and the pre-modification value for
//             set/clear) is returned on a valid/ready response channel.
//  Ports    : clk, rst                      - clock, async active-high reset
//             req_valid/req_ready/req_op/req_addr/req_wdata - request channel
//             rsp_valid/rsp_ready/rsp_rdata - response channel
//             A, WD, WE                     - registered bus outputs
//             RD                            - bus read data, combinational in A
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module periph_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] WD,
    output logic              WE,
    input  logic [DATA_W-1:0] RD
);

    localparam int              c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [1:0]      c_op_read  = 2'b00;
    localparam logic [1:0]      c_op_write = 2'b01;
    localparam logic [1:0]      c_op_set   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RMW_WR = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // ---------------- request FIFO ----------------
    logic [1:0]         r_fifo_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push, w_pop, w_empty, w_full;

    // ---------------- current operation / outputs ----------------
    logic [1:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [ADDR_W-1:0]  r_a,  w_a_nxt;
    logic [DATA_W-1:0]  r_wd, w_wd_nxt;
    logic               r_we, w_we_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;

    assign A         = r_a;
    assign WD        = r_wd;
    assign WE        = r_we;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    // FIFO storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]   <= req_op;
            r_fifo_addr[r_wr_ptr] <= req_addr;
            r_fifo_data[r_wr_ptr] <= req_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next registered outputs. Bus outputs are computed one
    // cycle ahead so that A/WD/WE come straight from flops.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_a_nxt         = '0;
        w_wd_nxt        = '0;
        w_we_nxt        = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                    w_a_nxt     = r_fifo_addr[r_rd_ptr];
                    if (r_fifo_op[r_rd_ptr] == c_op_write) begin
                        w_wd_nxt = r_fifo_data[r_rd_ptr];
                        w_we_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_op == c_op_write) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    // rsp_rdata doubles as the old-value register for RMW;
                    // the write-back value is formed from RD at the same edge.
                    w_rsp_rdata_nxt = RD;
                    if (r_op == c_op_read) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RMW_WR;
                        w_a_nxt     = r_addr;
                        w_we_nxt    = 1'b1;
                        w_wd_nxt    = (r_op == c_op_set) ? (RD | r_data)
                                                         : (RD & ~r_data);
                    end
                end
            end
            S_RMW_WR: begin
                w_state_nxt     = S_RESP;
                w_rsp_valid_nxt = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, FIFO pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_op        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_a         <= '0;
            r_wd        <= '0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_a         <= w_a_nxt;
            r_wd        <= w_wd_nxt;
            r_we        <= w_we_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_op     <= r_fifo_op[r_rd_ptr];
                r_addr   <= r_fifo_addr[r_rd_ptr];
                r_data   <= r_fifo_data[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_master.sv
// ============================================================================
//  Module   : tb_periph_bus_master
//  Purpose  : Self-checking bench for periph_bus_master. A register-file
//             peripheral model drives RD; a request-level reference model
//             predicts responses and bus writes into queues that a negedge
//             monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_periph_bus_master;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] A;
    logic [DW-1:0] WD;
    logic          WE;
    logic [DW-1:0] RD;

    periph_bus_master #(.FIFO_DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .A(A), .WD(WD), .WE(WE), .RD(RD)
    );

    always #5 clk = ~clk;

    // Peripheral register file: combinational read, write on rising clk.
    logic [DW-1:0] mem [32];
    logic          pre_en;
    logic [AW-1:0] pre_a;
    logic [DW-1:0] pre_d;
    assign RD = mem[A];
    always @(posedge clk) begin
        if (pre_en)  mem[pre_a] <= pre_d;
        else if (WE) mem[A]     <= WD;
    end

    // Reference model: register contents as seen by requests in order.
    logic [DW-1:0]    ref_mem [32];
    logic [DW-1:0]    rq [$];
    logic [AW+DW-1:0] wq [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void accept(input logic [1:0] op, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
        logic [DW-1:0] old;
        old = ref_mem[a];
        case (op)
            2'b00: rq.push_back(old);
            2'b01: begin wq.push_back({a, d}); ref_mem[a] = d; end
            2'b10: begin rq.push_back(old); wq.push_back({a, old | d}); ref_mem[a] = old | d; end
            default: begin rq.push_back(old); wq.push_back({a, old & ~d}); ref_mem[a] = old & ~d; end
        endcase
    endfunction

    // Monitor: every response handshake and every WE cycle must match the
    // oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_rdata), 64'hDEAD);
                else                chk("rsp_rdata", 64'(rsp_rdata), 64'(rq.pop_front()));
            end
            if (WE) begin
                if (wq.size() == 0) chk("we_unexpected", 64'({A, WD}), 64'hDEAD);
                else                chk("bus_write", 64'({A, WD}), 64'(wq.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rnd);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
            done = req_ready;
            @(posedge clk);
            if (done) accept(op, a, d);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] snap;
    bit            found;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; pre_en = 1'b0; pre_a = '0; pre_d = '0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_A", 64'(A), 64'd0);
        chk("rst_WD", 64'(WD), 64'd0);
        chk("rst_WE", 64'(WE), 64'd0);

        step();
        for (int i = 0; i < 32; i++) begin
            pre_en = 1'b1;
            pre_a  = AW'(i);
            pre_d  = (i == 0) ? 32'h0000_1234 : (i == 20) ? 32'h0000_000F : $urandom;
            ref_mem[i] = pre_d;
            step();
        end
        pre_en = 1'b0;
        rst    = 1'b0;
        step();

        // Write: one WE cycle, no response
        send(2'b01, 5'd4, 32'h0000_00FF, 1'b0);
        chk("wr_we_before", 64'(WE), 64'd0);
        step();
        chk("wr_we", 64'(WE), 64'd1);
        chk("wr_A", 64'(A), 64'd4);
        chk("wr_WD", 64'(WD), 64'hFF);
        chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        chk("wr_we_after", 64'(WE), 64'd0);
        chk("wr_A_after", 64'(A), 64'd0);
        chk("wr_no_rsp2", 64'(rsp_valid), 64'd0);

        // Read with response held off for three cycles
        rsp_ready = 1'b0;
        send(2'b00, 5'd0, 32'd0, 1'b0);
        step();
        chk("rd_rsp_early", 64'(rsp_valid), 64'd0);
        chk("rd_A", 64'(A), 64'd0);
        step();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rd_hold_rdata", 64'(rsp_rdata), 64'h1234);
        end
        rsp_ready = 1'b1;
        step();
        chk("rd_rsp_done", 64'(rsp_valid), 64'd0);

        // Set bits 0xF0 on reg 0x0F
        send(2'b10, 5'd20, 32'h0000_00F0, 1'b0);
        step();
        chk("set_issue_A", 64'(A), 64'd20);
        chk("set_issue_we", 64'(WE), 64'd0);
        step();
        chk("set_we", 64'(WE), 64'd1);
        chk("set_A", 64'(A), 64'd20);
        chk("set_WD", 64'(WD), 64'hFF);
        step();
        chk("set_we_off", 64'(WE), 64'd0);
        chk("set_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("set_rsp_rdata", 64'(rsp_rdata), 64'h0F);
        step(); step();

        // Clear bits 0x03 on reg 0xFF
        send(2'b11, 5'd20, 32'h0000_0003, 1'b0);
        step(); step();
        chk("clr_we", 64'(WE), 64'd1);
        chk("clr_WD", 64'(WD), 64'hFC);
        step();
        chk("clr_rsp_rdata", 64'(rsp_rdata), 64'hFF);
        step(); step();

        // Back-pressure: six reads with the response side stalled
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b00;
            req_addr  = AW'(i + 1);
            req_wdata = $urandom;
            chk("fill_req_ready", 64'(req_ready), 64'(i < 5));
            if (i < 5) begin
                @(posedge clk);
                accept(2'b00, req_addr, req_wdata);
                #1;
            end
        end
        rsp_ready = 1'b1;
        send(2'b00, 5'd6, req_wdata, 1'b0);
        for (int i = 0; i < 100 && rq.size() != 0; i++) step();
        chk("fill_drained", 64'(rq.size()), 64'd0);
        step(); step();

        // Reset during the RMW write cycle
        snap = ref_mem[20];
        send(2'b10, 5'd20, 32'h0000_FF00, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (WE) found = 1'b1;
            else    step();
        end
        chk("rmw_we_seen", 64'(found), 64'd1);
        rst = 1'b1;
        rq.delete();
        wq.delete();
        ref_mem[20] = snap;
        #1;
        chk("mid_rst_WE", 64'(WE), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_A", 64'(A), 64'd0);
        step(); step(); step();
        rst = 1'b0;
        repeat (6) step();
        chk("rmw_discarded", 64'(mem[20]), 64'(snap));
        send(2'b00, 5'd20, 32'd0, 1'b0);
        repeat (4) step();

        // Randomized traffic with random response back-pressure
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) != 0)
                send(2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), $urandom, 1'b1);
            else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && (rq.size() != 0 || wq.size() != 0); i++) step();
        repeat (4) step();
        chk("final_rq_empty", 64'(rq.size()), 64'd0);
        chk("final_wq_empty", 64'(wq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
